sys1_input_cond: RTL and testbench

- Input conditioning stage directly upstream of the SEGASYSTEM1 game core's INP0/INP1/INP2 ports.
- Replaces the raw combinational OR of keyboard and joystick bits with:
  - 2-flop synchronisers and tick-based debounce;
  - the P1/P2 control merge;
  - per-channel coin pulse shaping timed in frames, with a small queue for coins inserted back-to-back.
- Produces the active-low input bytes the core samples.

---
 rtl/sys1_input_cond_if.sv | 26 ++
 rtl/sys1_input_cond.sv | 168 ++++++++++++++++
 tb/tb_sys1_input_cond.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys1_input_cond_if.sv
// Signal bundle between the input conditioner and its neighbours.
// COIN_TOTAL exists only when SYS1_COIN_COUNTER_EN is defined.
interface sys1_input_cond_if;
  logic       VBLK;
  logic [6:0] P1;
  logic [6:0] P2;
  logic [1:0] START;
  logic [1:0] COIN;
  logic       MIRROR_P2;
  logic [7:0] INP0;
  logic [7:0] INP1;
  logic [7:0] INP2;
`ifdef SYS1_COIN_COUNTER_EN
  logic [15:0] COIN_TOTAL;

  modport master (output VBLK, P1, P2, START, COIN, MIRROR_P2,
                  input  INP0, INP1, INP2, COIN_TOTAL);
  modport slave  (input  VBLK, P1, P2, START, COIN, MIRROR_P2,
                  output INP0, INP1, INP2, COIN_TOTAL);
`else
  modport master (output VBLK, P1, P2, START, COIN, MIRROR_P2,
                  input  INP0, INP1, INP2);
  modport slave  (input  VBLK, P1, P2, START, COIN, MIRROR_P2,
                  output INP0, INP1, INP2);
`endif
endinterface

// File: rtl/sys1_input_cond.sv
// Input conditioning for the SEGASYSTEM1 core: sync, debounce, P1/P2 merge, coin pulse shaping.
// Optional coin-insert counter on io.COIN_TOTAL when SYS1_COIN_COUNTER_EN is defined.
module sys1_input_cond #(
  parameter int unsigned DEB_CYCLES      = 48000,
  parameter int unsigned COIN_FRAMES     = 4,
  parameter int unsigned COIN_GAP_FRAMES = 4
) (
  input  logic            clk48M,
  input  logic            reset,
  sys1_input_cond_if.slave io
);
  localparam int unsigned PW   = $clog2(DEB_CYCLES);
  localparam int unsigned MAXF = (COIN_FRAMES > COIN_GAP_FRAMES) ? COIN_FRAMES : COIN_GAP_FRAMES;
  localparam int unsigned FW   = (MAXF > 1) ? $clog2(MAXF) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(DEB_CYCLES - 1);
  localparam logic [FW-1:0] PULSE_LAST = FW'(COIN_FRAMES - 1);
  localparam logic [FW-1:0] GAP_LAST   = FW'(COIN_GAP_FRAMES - 1);

  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_GAP} coin_st_e;

  // Bit map of all conditioned inputs: [6:0] P1, [13:7] P2, [15:14] START, [17:16] COIN
  logic [17:0]   raw;
  logic [17:0]   sync1_q, sync2_q;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  logic [17:0]   hist0_q, hist1_q;
  logic [17:0]   same;
  logic [17:0]   deb_q, deb_d;
  logic [1:0]    coin_prev_q;
  logic [1:0]    coin_ev;
  logic          vblk_q;
  logic          vedge;
  logic [6:0]    ctl0;
  logic [7:0]    inp0_q, inp0_d;
  logic [7:0]    inp1_q, inp1_d;
  logic [7:0]    inp2_q, inp2_d;

  coin_st_e      st_q   [2];
  logic [FW-1:0] fcnt_q [2];
  logic [1:0]    pend_q [2];

  always_comb begin
    raw   = {io.COIN, io.START, io.P2, io.P1};
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;
    // The sample being shifted in is the third history entry, so the update uses it directly.
    same  = ~(sync2_q ^ hist0_q) & ~(hist0_q ^ hist1_q);
    deb_d = deb_q;
    if (tick) begin
      deb_d = (same & sync2_q) | (~same & deb_q);
    end
    coin_ev = deb_q[17:16] & ~coin_prev_q;
    vedge   = io.VBLK & ~vblk_q;
    ctl0    = io.MIRROR_P2 ? (deb_q[6:0] | deb_q[13:7]) : deb_q[6:0];
    inp0_d  = ~{ctl0[6:3], 1'b0, ctl0[2:0]};
    inp1_d  = ~{deb_q[13:10], 1'b0, deb_q[9:7]};
    inp2_d  = ~{2'b00, deb_q[15], deb_q[14], 2'b00,
                st_q[1] == C_PULSE, st_q[0] == C_PULSE};
  end

  always_ff @(posedge clk48M) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      pre_q       <= '0;
      hist0_q     <= '0;
      hist1_q     <= '0;
      deb_q       <= '0;
      coin_prev_q <= '0;
      vblk_q      <= 1'b0;
      inp0_q      <= '1;
      inp1_q      <= '1;
      inp2_q      <= '1;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      pre_q       <= pre_d;
      if (tick) begin
        hist0_q <= sync2_q;
        hist1_q <= hist0_q;
      end
      deb_q       <= deb_d;
      coin_prev_q <= deb_q[17:16];
      vblk_q      <= io.VBLK;
      inp0_q      <= inp0_d;
      inp1_q      <= inp1_d;
      inp2_q      <= inp2_d;
    end
  end

  always_ff @(posedge clk48M) begin
    for (int unsigned ch = 0; ch < 2; ch++) begin
      if (reset) begin
        st_q[ch]   <= C_IDLE;
        fcnt_q[ch] <= '0;
        pend_q[ch] <= '0;
      end else begin
        case (st_q[ch])
          C_IDLE: begin
            if (coin_ev[ch]) begin
              st_q[ch]   <= C_PULSE;
              fcnt_q[ch] <= '0;
            end else if (pend_q[ch] != 2'd0) begin
              st_q[ch]   <= C_PULSE;
              pend_q[ch] <= pend_q[ch] - 2'd1;
              fcnt_q[ch] <= '0;
            end
          end
          C_PULSE: begin
            if (coin_ev[ch] && (pend_q[ch] != 2'd3)) begin
              pend_q[ch] <= pend_q[ch] + 2'd1;
            end
            if (vedge) begin
              if (fcnt_q[ch] == PULSE_LAST) begin
                st_q[ch]   <= C_GAP;
                fcnt_q[ch] <= '0;
              end else begin
                fcnt_q[ch] <= fcnt_q[ch] + 1'b1;
              end
            end
          end
          C_GAP: begin
            if (coin_ev[ch] && (pend_q[ch] != 2'd3)) begin
              pend_q[ch] <= pend_q[ch] + 2'd1;
            end
            if (vedge) begin
              if (fcnt_q[ch] == GAP_LAST) begin
                st_q[ch]   <= C_IDLE;
                fcnt_q[ch] <= '0;
              end else begin
                fcnt_q[ch] <= fcnt_q[ch] + 1'b1;
              end
            end
          end
          default: begin
            st_q[ch]   <= C_IDLE;
            fcnt_q[ch] <= '0;
          end
        endcase
      end
    end
  end

  assign io.INP0 = inp0_q;
  assign io.INP1 = inp1_q;
  assign io.INP2 = inp2_q;

`ifdef SYS1_COIN_COUNTER_EN
  logic [1:0]  enter;
  logic [15:0] total_q, total_d;

  always_comb begin
    enter[0] = (st_q[0] == C_IDLE) && (coin_ev[0] || (pend_q[0] != 2'd0));
    enter[1] = (st_q[1] == C_IDLE) && (coin_ev[1] || (pend_q[1] != 2'd0));
    total_d  = total_q + {15'd0, enter[0]} + {15'd0, enter[1]};
  end

  always_ff @(posedge clk48M) begin
    if (reset) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign io.COIN_TOTAL = total_q;
`endif
endmodule

// File: tb/tb_sys1_input_cond.sv
// Directed bench for sys1_input_cond with a cycle-level behavioural model and per-cycle compare.
module tb_sys1_input_cond;
  localparam int DEB = 4;
  localparam int CF  = 2;
  localparam int CG  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vblk_en = 1'b1;
  int   vcnt;
  int   checks = 0;
  int   errors = 0;

  sys1_input_cond_if io();

  sys1_input_cond #(.DEB_CYCLES(DEB), .COIN_FRAMES(CF), .COIN_GAP_FRAMES(CG)) dut (
    .clk48M (clk),
    .reset  (rst),
    .io     (io)
  );

  initial forever #5 clk = ~clk;

  initial begin
    io.VBLK = 1'b0;
    vcnt = 0;
    forever begin
      @(negedge clk);
      if (vblk_en) begin
        io.VBLK = (vcnt < 4);
        vcnt = (vcnt + 1) % 40;
      end else begin
        io.VBLK = 1'b0;
        vcnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: inputs are seen two clocks late, sampled every DEB clocks, and a bit
  // follows its samples once the last three agree; coins are tracked as phase + frames seen.
  bit          m_valid = 1'b0;
  int          m_phase;
  logic [17:0] m_dly[$];
  logic [17:0] m_samp[$];
  logic [17:0] m_deb;
  logic [1:0]  m_prev;
  logic        m_vprev;
  int          m_state[2];
  int          m_frames[2];
  int          m_pend[2];
  logic [15:0] m_total;
  int          m_vcount = 0;
  logic [7:0]  m_inp0, m_inp1, m_inp2;

  function automatic logic [7:0] ctl_byte(input logic [6:0] c);
    return ~{c[6:3], 1'b0, c[2:0]};
  endfunction

  task automatic model_step();
    logic [17:0] s;
    logic [1:0]  ev;
    logic        ve;
    logic [6:0]  c0;
    if (rst) begin
      m_valid = 1'b1;
      m_phase = 0;
      m_dly   = '{18'd0, 18'd0};
      m_samp  = '{18'd0, 18'd0, 18'd0};
      m_deb   = '0;
      m_prev  = '0;
      m_vprev = 1'b0;
      m_total = '0;
      for (int ch = 0; ch < 2; ch++) begin
        m_state[ch] = 0; m_frames[ch] = 0; m_pend[ch] = 0;
      end
      m_inp0 = 8'hFF; m_inp1 = 8'hFF; m_inp2 = 8'hFF;
    end else begin
      c0 = io.MIRROR_P2 ? (m_deb[6:0] | m_deb[13:7]) : m_deb[6:0];
      m_inp0 = ctl_byte(c0);
      m_inp1 = ctl_byte(m_deb[13:7]);
      m_inp2 = ~{2'b00, m_deb[15], m_deb[14], 2'b00, m_state[1] == 1, m_state[0] == 1};
      ev = m_deb[17:16] & ~m_prev;
      ve = io.VBLK && !m_vprev;
      if (ve) m_vcount++;
      for (int ch = 0; ch < 2; ch++) begin
        if (m_state[ch] == 0) begin
          if (ev[ch]) begin
            m_state[ch] = 1; m_frames[ch] = 0; m_total = m_total + 16'd1;
          end else if (m_pend[ch] > 0) begin
            m_state[ch] = 1; m_frames[ch] = 0; m_pend[ch]--; m_total = m_total + 16'd1;
          end
        end else begin
          if (ev[ch] && m_pend[ch] < 3) m_pend[ch]++;
          if (ve) begin
            m_frames[ch]++;
            if (m_state[ch] == 1 && m_frames[ch] == CF) begin
              m_state[ch] = 2; m_frames[ch] = 0;
            end else if (m_state[ch] == 2 && m_frames[ch] == CG) begin
              m_state[ch] = 0; m_frames[ch] = 0;
            end
          end
        end
      end
      m_prev  = m_deb[17:16];
      m_vprev = io.VBLK;
      s = m_dly.pop_front();
      m_dly.push_back({io.COIN, io.START, io.P2, io.P1});
      if (m_phase == DEB - 1) begin
        m_samp.push_back(s);
        void'(m_samp.pop_front());
        for (int b = 0; b < 18; b++) begin
          if (m_samp[0][b] == m_samp[1][b] && m_samp[1][b] == m_samp[2][b]) m_deb[b] = m_samp[2][b];
        end
      end
      m_phase = (m_phase + 1) % DEB;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("cmp_inp0", {8'h00, io.INP0}, {8'h00, m_inp0});
      check("cmp_inp1", {8'h00, io.INP1}, {8'h00, m_inp1});
      check("cmp_inp2", {8'h00, io.INP2}, {8'h00, m_inp2});
`ifdef SYS1_COIN_COUNTER_EN
      check("cmp_total", io.COIN_TOTAL, m_total);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int          fe_vedges, seen_fe, last_v, pulses;
    logic        bit_bad, prev0;
    logic [7:0]  glitch_val;
    logic [15:0] total0;

    // 1: reset with everything pressed
    io.P1 = '1; io.P2 = '1; io.START = '1; io.COIN = '1; io.MIRROR_P2 = 1'b1;
    @(negedge clk);
    check("rst_inp0", {8'h00, io.INP0}, 16'h00FF);
    check("rst_inp1", {8'h00, io.INP1}, 16'h00FF);
    check("rst_inp2", {8'h00, io.INP2}, 16'h00FF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_inp0", {8'h00, io.INP0}, 16'h00FF);
    check("post_rst_inp2", {8'h00, io.INP2}, 16'h00FF);
    for (int i = 0; i < 16 && io.INP0 != 8'h08; i++) @(negedge clk);
    check("all_pressed_inp0", {8'h00, io.INP0}, 16'h0008);
    io.P1 = '0; io.P2 = '0; io.START = '0; io.COIN = '0; io.MIRROR_P2 = 1'b0;
    cyc(400);

    // 2: held press and short glitch
    io.P1[6] = 1'b1;
    for (int i = 0; i < 16 && io.INP0[7] != 1'b0; i++) @(negedge clk);
    check("left_held", {15'd0, io.INP0[7]}, 16'd0);
    io.P1[6] = 1'b0;
    cyc(20);
    glitch_val = 8'hFF;
    io.P1[6] = 1'b1;
    cyc(3);
    io.P1[6] = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (io.INP0 != 8'hFF) glitch_val = io.INP0;
    end
    check("glitch_inp0", {8'h00, glitch_val}, 16'h00FF);

    // 3: single coin pulse spans two frames
    fe_vedges = 0; seen_fe = 0; bit_bad = 1'b0; last_v = m_vcount;
    io.COIN[0] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 14) io.COIN[0] = 1'b0;
      if (io.INP2 == 8'hFE) begin
        seen_fe++;
        fe_vedges += m_vcount - last_v;
      end
      if (!io.INP2[1]) bit_bad = 1'b1;
      last_v = m_vcount;
    end
    check("coin1_seen", {15'd0, seen_fe != 0}, 16'd1);
    check("coin1_frames", 16'(fe_vedges), 16'd2);
    check("coin2_idle", {15'd0, bit_bad}, 16'd0);
    check("coin1_end_inp2", {8'h00, io.INP2}, 16'h00FF);

    // 4: five inserts during the first pulse -> one dropped
    pulses = 0; prev0 = io.INP2[0];
    total0 = '0;
`ifdef SYS1_COIN_COUNTER_EN
    total0 = io.COIN_TOTAL;
`endif
    for (int i = 0; i < 1000; i++) begin
      io.COIN[0] = (i < 140) && ((i % 28) < 14);
      @(negedge clk);
      if (prev0 && !io.INP2[0]) pulses++;
      prev0 = io.INP2[0];
    end
    check("queued_pulses", 16'(pulses), 16'd4);
`ifdef SYS1_COIN_COUNTER_EN
    check("coin_total_delta", io.COIN_TOTAL - total0, 16'd4);
`endif

    // 5: mirror merge
    io.MIRROR_P2 = 1'b1;
    io.P2[4] = 1'b1;
    cyc(20);
    check("mirror_inp0_up", {15'd0, io.INP0[5]}, 16'd0);
    check("mirror_inp1_up", {15'd0, io.INP1[5]}, 16'd0);
    io.MIRROR_P2 = 1'b0;
    cyc(2);
    check("nomirror_inp0_up", {15'd0, io.INP0[5]}, 16'd1);
    check("nomirror_inp1_up", {15'd0, io.INP1[5]}, 16'd0);
    io.P2[4] = 1'b0;
    cyc(30);

    // 6: reset in the middle of a pulse with two queued
    vblk_en = 1'b0;
    for (int i = 0; i < 84; i++) begin
      io.COIN[0] = ((i % 28) < 14);
      @(negedge clk);
    end
    io.COIN[0] = 1'b0;
    cyc(20);
    check("stuck_pulse_inp2", {8'h00, io.INP2}, 16'h00FE);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_inp2", {8'h00, io.INP2}, 16'h00FF);
    check("rst_mid_inp0", {8'h00, io.INP0}, 16'h00FF);
`ifdef SYS1_COIN_COUNTER_EN
    check("rst_mid_total", io.COIN_TOTAL, 16'd0);
`endif
    rst = 1'b0;
    vblk_en = 1'b1;
    bit_bad = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!io.INP2[0]) bit_bad = 1'b1;
    end
    check("no_pulse_after_rst", {15'd0, bit_bad}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
